// File: rtl/gray_sweep_ctrl_if.sv
// gray_sweep_ctrl_if: request/converter signal bundle for the Gray sweep controller
interface gray_sweep_ctrl_if #(parameter int WIDTH = 4);
  logic start;
  logic dir;
  logic hold;
  logic [WIDTH-1:0] grayOut;
  logic [WIDTH-1:0] binIn;
  logic busy;
  logic done;
  logic errFlag;
  logic [WIDTH:0] errCount;
  logic [WIDTH-1:0] firstErr;
  modport master(output start, dir, hold, binIn,
                 input grayOut, busy, done, errFlag, errCount, firstErr);
  modport slave(input start, dir, hold, binIn,
                output grayOut, busy, done, errFlag, errCount, firstErr);
endinterface

// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: sweeps every Gray code through an external converter and tallies mismatches
module gray_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rstN,
  gray_sweep_ctrl_if.slave bus
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE + 1) : 1;
  localparam logic [WIDTH-1:0] LAST = '1;
  typedef enum logic [2:0] {stIdle, stDrive, stSettle, stCheck, stDone} state_t;
  state_t state;
  logic [WIDTH-1:0] idx;
  logic [CW-1:0] cnt;
  logic down;
  logic term;
  assign term = down ? idx == '0 : idx == LAST;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= stIdle;
      idx <= '0;
      cnt <= '0;
      down <= 1'b0;
      bus.grayOut <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.errFlag <= 1'b0;
      bus.errCount <= '0;
      bus.firstErr <= '0;
    end else begin
      case (state)
        stIdle: if (bus.start) begin
          down <= bus.dir;
          idx <= bus.dir ? LAST : '0;
          bus.errFlag <= 1'b0;
          bus.errCount <= '0;
          bus.firstErr <= '0;
          bus.busy <= 1'b1;
          state <= stDrive;
        end
        stDrive: if (!bus.hold) begin
          bus.grayOut <= idx ^ (idx >> 1);
          cnt <= CW'(SETTLE);
          state <= SETTLE == 0 ? stCheck : stSettle;
        end
        stSettle: if (!bus.hold) begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= stCheck;
        end
        stCheck: if (!bus.hold) begin
          if (bus.binIn != idx) begin
            bus.errCount <= bus.errCount + 1'b1;
            bus.errFlag <= 1'b1;
            if (!bus.errFlag) bus.firstErr <= idx;
          end
          // terminal test comes before the step so idx never wraps
          if (term) begin
            bus.done <= 1'b1;
            state <= stDone;
          end else begin
            idx <= down ? idx - 1'b1 : idx + 1'b1;
            state <= stDrive;
          end
        end
        stDone: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= stIdle;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= stIdle;
        end
      endcase
    end
  end
endmodule

// File: doc/gray_sweep_ctrl.md
GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 The block SHALL have parameter SETTLE, default 1, giving the number of wait cycles between driving a code and sampling the result (0 allowed).
REQ-003 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rstN.
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port rstN  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  request one full sweep; sampled only in IDLE.
REQ-007 Port dir  input  1  sweep direction latched at start: 0 = up (0 to 2^WIDTH-1), 1 = down (2^WIDTH-1 to 0).
REQ-008 Port hold  input  1  pause; freezes state, index and counters while high.
REQ-009 Port grayOut  output  WIDTH  registered Gray code driven to the external Gray-to-binary converter.
REQ-010 Port binIn  input  WIDTH  binary result returned by the converter.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port done  output  1  one-cycle pulse at sweep completion.
REQ-013 Port errFlag  output  1  high if any mismatch occurred in the last sweep.
REQ-014 Port errCount  output  WIDTH+1  number of mismatches in the last sweep.
REQ-015 Port firstErr  output  WIDTH  binary index of the first mismatch in the last sweep; 0 if none.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-017 IDLE, start=1: latch dir; load idx to 0 (up) or 2^WIDTH-1 (down); clear errFlag, errCount, firstErr; go to DRIVE.
REQ-018 DRIVE: register grayOut = idx XOR (idx >> 1); load settle counter with SETTLE; go to SETTLE, or directly to CHECK if SETTLE = 0.
REQ-019 SETTLE: decrement the counter each cycle; go to CHECK in the cycle after the counter reaches 1.
REQ-020 CHECK: compare binIn to idx; on mismatch, increment errCount and set errFlag; on the first mismatch only, capture idx into firstErr.
REQ-021 CHECK exit: if idx is the terminal value (2^WIDTH-1 up, 0 down), go to DONE; otherwise step idx by +1 (up) or -1 (down) and go to DRIVE.
REQ-022 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-023 Each code SHALL occupy exactly 2+SETTLE cycles; DONE SHALL be entered 2^WIDTH*(2+SETTLE) rising edges after the edge that samples start (48 for defaults).
REQ-024 idx SHALL never wrap; the terminal check precedes the step.
REQ-025 errCount SHALL not saturate; its maximum is 2^WIDTH, which fits in WIDTH+1 bits.
REQ-026 start SHALL be ignored while busy=1; dir changes after start SHALL have no effect on a running sweep.
REQ-027 hold=1 in DRIVE, SETTLE or CHECK SHALL freeze all registers, with no compare or count occurring; hold in IDLE or DONE SHALL have no effect.
REQ-028 grayOut SHALL change only on entry to DRIVE and otherwise hold its value, including in IDLE after a sweep.
REQ-029 errFlag, errCount and firstErr SHALL hold their values from the end of a sweep until the next accepted start.

Reset
REQ-030 rstN=0 SHALL asynchronously force state=IDLE, idx=0, grayOut=0, busy=0, done=0, errFlag=0, errCount=0, firstErr=0, settle counter=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep without a done pulse; the first start accepted after release SHALL begin a fresh sweep.

Verification
REQ-032 Ideal converter, defaults, dir=0, start pulse -> grayOut sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; done 48 edges after start; errCount=0, errFlag=0.
REQ-033 Ideal converter, dir=1 -> grayOut sequence starts at 1000 and ends at 0000; done after 48 edges; errCount=0.
REQ-034 Converter model with binIn[0] stuck at 0, dir=0 -> errCount=8, errFlag=1, firstErr=0001.
REQ-035 hold high for 5 cycles in the middle of the sweep -> done delayed to 53 edges after start; results match REQ-032.
REQ-036 start pulsed again at edge 10 -> ignored and sweep completes at edge 48; rstN low at edge 20 -> all outputs at reset values, no done pulse.
REQ-037 SETTLE=0 -> done 32 edges after start; SETTLE=3 -> done 80 edges after start; errCount=0 in both cases.
